// File: rtl/food_spawn_ctrl.sv
// food_spawn_ctrl: picks a free grid cell for the next food item and commits it to the renderer
// Build option: define FOOD_SPAWN_TIMEOUT_EN to treat an occupancy query left unanswered for
// ACK_TIMEOUT cycles as an occupied cell; without it QUERY waits for i_occ_ack indefinitely.
// Ports:
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_eat                 1-cycle spawn request (snake head hit food)
//   o_occ_req, o_occ_x/y  occupancy query and candidate pixel coordinates, held until ack
//   i_occ_ack, i_occ_hit  query answer; hit=1 means a snake segment occupies the cell
//   o_food_x/y, o_ate     committed food pixel position and its 1-cycle commit strobe
//   o_busy, o_fail        spawn in progress; commit forced after MAX_TRIES occupied candidates
module food_spawn_ctrl #(
  parameter int unsigned GRID_W      = 40,
  parameter int unsigned GRID_H      = 30,
  parameter int unsigned MAX_TRIES   = 8,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned ACK_TIMEOUT = 15
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_eat,
  output logic       o_occ_req,
  output logic [9:0] o_occ_x,
  output logic [9:0] o_occ_y,
  input  logic       i_occ_ack,
  input  logic       i_occ_hit,
  output logic [9:0] o_food_x,
  output logic [9:0] o_food_y,
  output logic       o_ate,
  output logic       o_busy,
  output logic       o_fail
);
  typedef enum logic [1:0] {IDLE, GEN, QUERY, COMMIT} state_t;
  state_t      r_state, w_next;
  logic [15:0] r_lfsr;
  logic [3:0]  r_tries;
  logic        r_pending, r_forced;
  logic [5:0]  w_cx;
  logic [4:0]  w_cy;
  logic        w_ack, w_occ;
  if (MAX_TRIES < 1 || MAX_TRIES > 15 || LFSR_SEED == 16'h0 || ACK_TIMEOUT > 15) begin : g_bad_param
    $error("food_spawn_ctrl: parameter out of range");
  end
  // One conditional subtract folds the raw LFSR fields onto the playfield.
  assign w_cx = (r_lfsr[5:0] >= 6'(GRID_W)) ? r_lfsr[5:0] - 6'(GRID_W) : r_lfsr[5:0];
  assign w_cy = (r_lfsr[12:8] >= 5'(GRID_H)) ? r_lfsr[12:8] - 5'(GRID_H) : r_lfsr[12:8];
`ifdef FOOD_SPAWN_TIMEOUT_EN
  logic [3:0] r_wait;
  logic       w_to;
  assign w_to  = !i_occ_ack && r_wait == 4'(ACK_TIMEOUT);
  // An unanswered query is treated as an occupied cell.
  assign w_ack = i_occ_ack | w_to;
  assign w_occ = i_occ_hit | w_to;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_wait <= 4'd0;
    else          r_wait <= (r_state == QUERY && !i_occ_ack) ? r_wait + 4'd1 : 4'd0;
`else
  assign w_ack = i_occ_ack;
  assign w_occ = i_occ_hit;
`endif
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_state <= IDLE;
    else          r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = i_eat ? GEN : IDLE;
      GEN:     w_next = QUERY;
      QUERY:   w_next = !w_ack ? QUERY : (w_occ && r_tries < 4'(MAX_TRIES)) ? GEN : COMMIT;
      // An eat arriving in the commit cycle itself chains straight into the next spawn.
      COMMIT:  w_next = (r_pending || i_eat) ? GEN : IDLE;
      default: w_next = IDLE;
    endcase
  end
  always_comb begin
    o_occ_req = r_state == QUERY;
    o_ate     = r_state == COMMIT;
    o_fail    = r_state == COMMIT && r_forced;
    o_busy    = r_state != IDLE;
  end
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_lfsr    <= LFSR_SEED;
      r_tries   <= 4'd0;
      r_pending <= 1'b0;
      r_forced  <= 1'b0;
      o_occ_x   <= 10'd0;
      o_occ_y   <= 10'd0;
      o_food_x  <= 10'd304;
      o_food_y  <= 10'd448;
    end else begin
      r_lfsr    <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
      r_pending <= (r_state == COMMIT) ? 1'b0 : (r_state != IDLE) && (r_pending || i_eat);
      r_tries   <= (r_state == GEN) ? r_tries + 4'd1 : (r_state == QUERY) ? r_tries : 4'd0;
      if (r_state == GEN) begin
        o_occ_x <= {w_cx, 4'b0};
        o_occ_y <= {1'b0, w_cy, 4'b0};
      end
      // Food moves on the same edge that raises o_ate.
      if (r_state == QUERY && w_next == COMMIT) begin
        o_food_x <= o_occ_x;
        o_food_y <= o_occ_y;
        r_forced <= w_occ;
      end
    end
endmodule

// File: tb/tb_food_spawn_ctrl.sv
// tb_food_spawn_ctrl: scoreboard bench for food_spawn_ctrl
module tb_food_spawn_ctrl;
  localparam int MAX_TRIES   = 8;
  localparam int ACK_TIMEOUT = 15;
`ifdef FOOD_SPAWN_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 0, rst_n = 0, eat = 0, ack = 0, hit = 0;
  logic occ_req, ate, busy, fail;
  logic [9:0] occ_x, occ_y, food_x, food_y;
  int total = 0, bad = 0;
  int cyc = 0, n_req = 0, n_ate = 0, last_rise = 0;
  int ack_delay = 0, hits = 0, q_n = 0, w_n = 0;
  logic [15:0] m_lfsr;
  logic [9:0] m_cx = 0, m_cy = 0;
  logic [20:0] exp_q[$];
  logic [20:0] e;
  logic prev_req = 0;
  bit occ, tmo;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  food_spawn_ctrl dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_eat(eat),
    .o_occ_req(occ_req), .o_occ_x(occ_x), .o_occ_y(occ_y),
    .i_occ_ack(ack), .i_occ_hit(hit),
    .o_food_x(food_x), .o_food_y(food_y),
    .o_ate(ate), .o_busy(busy), .o_fail(fail)
  );

  function automatic logic [19:0] cand(input logic [15:0] l);
    logic [5:0] cx;
    logic [4:0] cy;
    cx = l[5:0];
    if (cx >= 6'd40) cx = cx - 6'd40;
    cy = l[12:8];
    if (cy >= 5'd30) cy = cy - 5'd30;
    return {cx, 4'b0, 1'b0, cy, 4'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  always @(posedge clk or negedge rst_n)
    if (!rst_n) m_lfsr <= 16'hACE1;
    else        m_lfsr <= (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);

  // Responder: answers queries after ack_delay cycles (-1: never); the first `hits` answers of a spawn are occupied.
  always @(negedge clk) begin
    if (!rst_n || !occ_req) begin
      ack = 0; hit = 0; w_n = 0;
      if (!rst_n) q_n = 0;
    end else begin
      ack = ack_delay >= 0 && w_n == ack_delay;
      hit = ack ? (q_n < hits) : 1'($urandom_range(0, 1));
      tmo = TO_EN && !ack && w_n == ACK_TIMEOUT;
      if (ack || tmo) begin
        occ = ack ? hit : 1'b1;
        if (!occ) begin exp_q.push_back({m_cx, m_cy, 1'b0}); q_n = 0; end
        else if (q_n + 1 == MAX_TRIES) begin exp_q.push_back({m_cx, m_cy, 1'b1}); q_n = 0; end
        else q_n++;
      end
      w_n++;
    end
  end

  // Monitor: tracks the candidate generated in GEN, checks queries and pops commits.
  always @(negedge clk) begin
    if (!rst_n) prev_req = 0;
    else begin
      if (busy && !occ_req && !ate) {m_cx, m_cy} = cand(m_lfsr);
      if (occ_req && !prev_req) begin
        n_req++;
        last_rise = cyc;
        chk("occ_x", occ_x, m_cx);
        chk("occ_y", occ_y, m_cy);
      end
      if (ate) begin
        n_ate++;
        chk("ate_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("food_x", food_x, e[20:11]);
          chk("food_y", food_y, e[10:1]);
          chk("fail", fail, e[0]);
        end
        chk("food_x_on_grid", food_x[3:0] == 4'd0 && food_x <= 10'd624, 1);
        chk("food_y_on_grid", food_y[3:0] == 4'd0 && food_y <= 10'd464, 1);
      end else if (fail) chk("fail_only_with_ate", fail, 0);
      prev_req = occ_req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_eat();
    eat = 1;
    tick();
    eat = 0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, busy, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r0, a0, t0, viol, n;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_food_x", food_x, 304);
    chk("rst_food_y", food_y, 448);
    chk("rst_occ_x", occ_x, 0);
    chk("rst_occ_y", occ_y, 0);
    chk("rst_req", occ_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ate", ate, 0);
    chk("rst_fail", fail, 0);
    rst_n = 1;
    viol = 0;
    repeat (100) begin
      @(negedge clk);
      if (ate || busy || occ_req || food_x != 10'd304 || food_y != 10'd448) viol++;
    end
    chk("idle_100_violations", viol, 0);
    // single spawn, immediate free answer
    tick();
    ack_delay = 0; hits = 0;
    pulse_eat();
    @(negedge clk); chk("lat_c1_busy", busy, 1); chk("lat_c1_req", occ_req, 0);
    @(negedge clk); chk("lat_c2_req", occ_req, 1); chk("lat_c2_ate", ate, 0);
    @(negedge clk); chk("lat_c3_ate", ate, 1); chk("lat_c3_fail", fail, 0);
    @(negedge clk); chk("lat_c4_ate", ate, 0); chk("lat_c4_busy", busy, 0);
    // three occupied answers then free
    tick();
    hits = 3; r0 = n_req; a0 = n_ate;
    pulse_eat();
    wait_idle(200, "retry3_done");
    chk("retry3_queries", n_req - r0, 4);
    chk("retry3_commits", n_ate - a0, 1);
    // always occupied: forced commit
    tick();
    hits = 100; r0 = n_req; a0 = n_ate;
    pulse_eat();
    wait_idle(200, "forced_done");
    chk("forced_queries", n_req - r0, 8);
    chk("forced_commits", n_ate - a0, 1);
    // two eats during a slow spawn collapse into one pending spawn
    tick();
    hits = 0; ack_delay = 5; a0 = n_ate;
    pulse_eat();
    tick(); tick();
    pulse_eat();
    tick();
    pulse_eat();
    n = 0;
    @(negedge clk);
    while (!ate && n < 50) begin @(negedge clk); n++; end
    chk("pend_first_ate", ate, 1);
    @(negedge clk);
    chk("pend_gen_busy", busy, 1);
    chk("pend_gen_req", occ_req, 0);
    chk("pend_gen_ate", ate, 0);
    wait_idle(100, "pend_done");
    chk("pend_commits", n_ate - a0, 2);
    // reset during a query
    tick();
    ack_delay = -1; a0 = n_ate;
    pulse_eat();
    n = 0;
    @(negedge clk);
    while (!occ_req && n < 10) begin @(negedge clk); n++; end
    chk("rstmid_req_seen", occ_req, 1);
    #2 rst_n = 0;
    #1;
    chk("rstmid_food_x", food_x, 304);
    chk("rstmid_food_y", food_y, 448);
    chk("rstmid_req", occ_req, 0);
    chk("rstmid_busy", busy, 0);
    chk("rstmid_ate", ate, 0);
    tick(); tick();
    rst_n = 1;
    repeat (20) @(negedge clk);
    chk("rstmid_no_commit", n_ate - a0, 0);
    chk("rstmid_queue", exp_q.size(), 0);
`ifdef FOOD_SPAWN_TIMEOUT_EN
    // no answers at all: each query times out, forced commit after MAX_TRIES
    tick();
    ack_delay = -1; r0 = n_req; a0 = n_ate; t0 = 0;
    pulse_eat();
    for (int k = 1; k <= MAX_TRIES; k++) begin
      n = 0;
      while (n_req < r0 + k && n < 40) begin @(negedge clk); n++; end
      chk("to_query_seen", n_req - r0, k);
      if (k > 1) chk("to_period", last_rise - t0, ACK_TIMEOUT + 2);
      t0 = last_rise;
    end
    wait_idle(40, "to_done");
    chk("to_commits", n_ate - a0, 1);
`endif
    tick();
    chk("queue_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
